// File: rtl/rf_wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arb_pkg
// Description : Shared encodings for the register-file write-back arbiter:
//               buffer FSM states, buffer depth and the buffered entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_wb_arb_pkg;

    // Buffer occupancy states (2-bit encoding shared with debug tooling)
    typedef enum logic [1:0] {
        WB_ST_EMPTY = 2'b00,
        WB_ST_ONE   = 2'b01,
        WB_ST_FULL  = 2'b10
    } wb_state_e;

    localparam int WB_FIFO_DEPTH = 2;
    localparam int WB_ADDR_W     = 5;
    localparam int WB_DATA_W     = 32;
    localparam int WB_ENT_W      = WB_ADDR_W + WB_DATA_W;

    // One buffered long-latency result: destination plus data (37 bits)
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_ent_t;

    // The write port is available to long results unless the ALU really writes
    function automatic logic slot_free(input logic wren, input logic [WB_ADDR_W-1:0] addr);
        return !wren || (addr == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_arb_wb_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo2
// Description : Two-entry FIFO holding long-latency results (addr+data) while
//               the ALU owns the write port. Occupancy is an explicit
//               EMPTY/ONE/FULL state machine; entry 0 is always the head.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo2
    import rf_wb_arb_pkg::*;
(
    input  logic                clock,
    input  logic                rst,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [WB_ENT_W-1:0] din_i,
    output logic [WB_ENT_W-1:0] head_o,
    output logic                full_o,
    output logic                empty_o
);

    wb_state_e           state_q;
    logic [WB_ENT_W-1:0] mem_q [WB_FIFO_DEPTH];
    logic                full_q;
    logic                empty_q;

    // Occupancy FSM with shift-to-head storage and registered full/empty flags
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= WB_ST_EMPTY;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                WB_ST_EMPTY: begin
                    // A pop request while empty has nothing to remove
                    if (push_i) begin
                        mem_q[0] <= din_i;
                        state_q  <= WB_ST_ONE;
                        empty_q  <= 1'b0;
                    end
                end
                WB_ST_ONE: begin
                    case ({push_i, pop_i})
                        2'b10: begin
                            mem_q[1] <= din_i;
                            state_q  <= WB_ST_FULL;
                            full_q   <= 1'b1;
                        end
                        2'b01: begin
                            state_q  <= WB_ST_EMPTY;
                            empty_q  <= 1'b1;
                        end
                        2'b11: begin
                            // Old head leaves, new entry becomes the head
                            mem_q[0] <= din_i;
                        end
                        default: ;
                    endcase
                end
                WB_ST_FULL: begin
                    if (pop_i) begin
                        mem_q[0] <= mem_q[1];
                        if (push_i) begin
                            mem_q[1] <= din_i;
                        end else begin
                            state_q <= WB_ST_ONE;
                            full_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= WB_ST_EMPTY;
                    full_q  <= 1'b0;
                    empty_q <= 1'b1;
                end
            endcase
        end
    end

    assign head_o  = mem_q[0];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule
`default_nettype wire

// File: rtl/rf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arb
// Description : Register-file write-back arbiter. ALU results always own the
//               write port; long-latency results (load, mul/div) are taken on
//               a valid/ready handshake and buffered in wb_fifo2 until a free
//               write slot appears. A pending-write scoreboard flags decode
//               hazards on registers still owed a long-latency result.
// Options     : RF_WB_BYPASS_EN - when defined, a result accepted with the
//               buffer empty and the slot free is written directly (1 cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arb
    import rf_wb_arb_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic        pause,
    input  logic        alu_wren,
    input  logic [4:0]  alu_wraddr,
    input  logic [31:0] alu_data,
    input  logic        lr_valid,
    output logic        lr_ready,
    input  logic [4:0]  lr_addr,
    input  logic [31:0] lr_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    output logic        iss_ready,
    input  logic [4:0]  chk_addr_a,
    input  logic [4:0]  chk_addr_b,
    output logic        hazard_a,
    output logic        hazard_b,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_wraddress,
    output logic        wb_wren
);

    // Scoreboard; bit 0 is held at 0 so r0 never reports a hazard
    logic [31:0] pending_q, pending_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic        wb_wren_q, wb_wren_d;

    logic        w_slot_free;
    logic        w_lr_acc;
    logic        w_iss_acc;
    logic        w_bypass;
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    wb_ent_t     w_head;
    wb_ent_t     w_lr_ent;

    assign w_slot_free = slot_free(alu_wren, alu_wraddr);

    // Handshakes are blocked while the pipeline is frozen
    assign lr_ready  = !pause && !w_fifo_full;
    assign w_lr_acc  = lr_valid && lr_ready;
    assign iss_ready = !pause && !pending_q[iss_addr];
    assign w_iss_acc = iss_valid && iss_ready;

`ifdef RF_WB_BYPASS_EN
    assign w_bypass = w_lr_acc && w_fifo_empty && w_slot_free && (lr_addr != 5'd0);
`else
    assign w_bypass = 1'b0;
`endif

    // r0 results are accepted but never stored, so they cost no buffer slot
    assign w_push = w_lr_acc && (lr_addr != 5'd0) && !w_bypass;
    assign w_pop  = !pause && w_slot_free && !w_fifo_empty;

    assign w_lr_ent.addr = lr_addr;
    assign w_lr_ent.data = lr_data;

    wb_fifo2 u_fifo (
        .clock   (clock),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_lr_ent),
        .head_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Pick the write-port winner and update the scoreboard (set beats clear)
    always_comb begin
        wb_data_d = '0;
        wb_addr_d = '0;
        wb_wren_d = 1'b0;
        pending_d = pending_q;

        if (!w_slot_free) begin
            wb_data_d = alu_data;
            wb_addr_d = alu_wraddr;
            wb_wren_d = 1'b1;
        end else if (w_pop) begin
            wb_data_d = w_head.data;
            wb_addr_d = w_head.addr;
            wb_wren_d = (w_head.addr != 5'd0);
            pending_d[w_head.addr] = 1'b0;
        end else if (w_bypass) begin
            wb_data_d = lr_data;
            wb_addr_d = lr_addr;
            wb_wren_d = 1'b1;
            pending_d[lr_addr] = 1'b0;
        end

        if (w_iss_acc && (iss_addr != 5'd0)) begin
            pending_d[iss_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Registered write port and scoreboard; pause freezes everything
    always_ff @(posedge clock) begin
        if (rst) begin
            wb_data_q <= '0;
            wb_addr_q <= '0;
            wb_wren_q <= 1'b0;
            pending_q <= '0;
        end else if (!pause) begin
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
            wb_wren_q <= wb_wren_d;
            pending_q <= pending_d;
        end
    end

    assign hazard_a     = pending_q[chk_addr_a];
    assign hazard_b     = pending_q[chk_addr_b];
    assign wb_data      = wb_data_q;
    assign wb_wraddress = wb_addr_q;
    assign wb_wren      = wb_wren_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arb
// Description : Self-checking bench for rf_wb_arb. A queue/bit-array model of
//               the write-back rules is compared against the DUT every cycle;
//               directed sequences add literal expectations on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arb;

    logic        clock = 1'b0;
    logic        rst, pause;
    logic        alu_wren;
    logic [4:0]  alu_wraddr;
    logic [31:0] alu_data;
    logic        lr_valid, lr_ready;
    logic [4:0]  lr_addr;
    logic [31:0] lr_data;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_addr;
    logic [4:0]  chk_addr_a, chk_addr_b;
    logic        hazard_a, hazard_b;
    logic [31:0] wb_data;
    logic [4:0]  wb_wraddress;
    logic        wb_wren;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    always #5 clock = ~clock;

    rf_wb_arb dut (
        .clock        (clock),
        .rst          (rst),
        .pause        (pause),
        .alu_wren     (alu_wren),
        .alu_wraddr   (alu_wraddr),
        .alu_data     (alu_data),
        .lr_valid     (lr_valid),
        .lr_ready     (lr_ready),
        .lr_addr      (lr_addr),
        .lr_data      (lr_data),
        .iss_valid    (iss_valid),
        .iss_addr     (iss_addr),
        .iss_ready    (iss_ready),
        .chk_addr_a   (chk_addr_a),
        .chk_addr_b   (chk_addr_b),
        .hazard_a     (hazard_a),
        .hazard_b     (hazard_b),
        .wb_data      (wb_data),
        .wb_wraddress (wb_wraddress),
        .wb_wren      (wb_wren)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pend = '0;
    logic        m_wren = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    always @(posedge clock) begin : p_model
        bit   free, acc, iacc, used;
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_pend = '0;
            m_wren = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else if (!pause) begin
            free = !(alu_wren && alu_wraddr != 5'd0);
            acc  = lr_valid && (m_q.size() < 2);
            iacc = iss_valid && !m_pend[iss_addr];
            used = 1'b0;
            m_wren = 1'b0;
            if (!free) begin
                m_wren = 1'b1; m_addr = alu_wraddr; m_data = alu_data;
            end else if (m_q.size() != 0) begin
                e = m_q.pop_front();
                m_wren = 1'b1; m_addr = e.a; m_data = e.d;
                m_pend[e.a] = 1'b0;
            end
`ifdef RF_WB_BYPASS_EN
            else if (acc && lr_addr != 5'd0) begin
                m_wren = 1'b1; m_addr = lr_addr; m_data = lr_data;
                m_pend[lr_addr] = 1'b0;
                used = 1'b1;
            end
`endif
            if (acc && lr_addr != 5'd0 && !used) begin
                e.a = lr_addr; e.d = lr_data;
                m_q.push_back(e);
            end
            if (iacc && iss_addr != 5'd0) m_pend[iss_addr] = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (chk_en && !rst) begin
            check("wb_wren", {31'd0, wb_wren}, {31'd0, m_wren});
            if (m_wren) begin
                check("wb_wraddress", {27'd0, wb_wraddress}, {27'd0, m_addr});
                check("wb_data", wb_data, m_data);
            end
            check("lr_ready", {31'd0, lr_ready}, {31'd0, (!pause && m_q.size() < 2)});
            check("iss_ready", {31'd0, iss_ready}, {31'd0, (!pause && !m_pend[iss_addr])});
            check("hazard_a", {31'd0, hazard_a}, {31'd0, m_pend[chk_addr_a]});
            check("hazard_b", {31'd0, hazard_b}, {31'd0, m_pend[chk_addr_b]});
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        pause = 0; alu_wren = 0; alu_wraddr = 0; alu_data = 0;
        lr_valid = 0; lr_addr = 0; lr_data = 0;
        iss_valid = 0; iss_addr = 0; chk_addr_a = 0; chk_addr_b = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        chk_en = 1;

        // Reset state
        check("rst wb_wren", {31'd0, wb_wren}, 32'd0);
        check("rst wb_data", wb_data, 32'd0);
        check("rst lr_ready", {31'd0, lr_ready}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            chk_addr_a = i[4:0];
            #1 check("rst hazard_a", {31'd0, hazard_a}, 32'd0);
        end
        tick();

        // ALU write, 1-cycle latency
        alu_wren = 1; alu_wraddr = 5; alu_data = 32'h1234;
        tick();
        alu_wren = 0;
        check("alu wren", {31'd0, wb_wren}, 32'd1);
        check("alu addr", {27'd0, wb_wraddress}, 32'd5);
        check("alu data", wb_data, 32'h1234);

        // Issue r9 then deliver its long result with the ALU idle
        iss_valid = 1; iss_addr = 9;
        #1 check("iss9 ready", {31'd0, iss_ready}, 32'd1);
        tick();
        iss_valid = 0; chk_addr_a = 9;
        #1 check("r9 hazard set", {31'd0, hazard_a}, 32'd1);
        lr_valid = 1; lr_addr = 9; lr_data = 32'hDEADBEEF;
        #1 check("r9 lr_ready", {31'd0, lr_ready}, 32'd1);
        tick();
        lr_valid = 0;
`ifdef RF_WB_BYPASS_EN
        check("r9 bypass wren", {31'd0, wb_wren}, 32'd1);
`else
        check("r9 buffered wren", {31'd0, wb_wren}, 32'd0);
        check("r9 hazard held", {31'd0, hazard_a}, 32'd1);
        tick();
        check("r9 buffered wren", {31'd0, wb_wren}, 32'd1);
`endif
        check("r9 addr", {27'd0, wb_wraddress}, 32'd9);
        check("r9 data", wb_data, 32'hDEADBEEF);
        #1 check("r9 hazard cleared", {31'd0, hazard_a}, 32'd0);
        tick();
        check("idle wren", {31'd0, wb_wren}, 32'd0);

        // ALU busy while three long results arrive
        alu_wren = 1; alu_wraddr = 1; alu_data = 32'h100;
        lr_valid = 1; lr_addr = 10; lr_data = 32'hA10;
        #1 check("lr10 ready", {31'd0, lr_ready}, 32'd1);
        tick();
        alu_wraddr = 2; alu_data = 32'h200; lr_addr = 11; lr_data = 32'hA11;
        #1 check("lr11 ready", {31'd0, lr_ready}, 32'd1);
        tick();
        check("alu2 addr", {27'd0, wb_wraddress}, 32'd2);
        alu_wraddr = 3; alu_data = 32'h300; lr_addr = 12; lr_data = 32'hA12;
        #1 check("full ready", {31'd0, lr_ready}, 32'd0);
        tick();
        check("alu3 addr", {27'd0, wb_wraddress}, 32'd3);
        alu_wren = 0;
        #1 check("full ready 2", {31'd0, lr_ready}, 32'd0);
        tick();
        check("drain1 addr", {27'd0, wb_wraddress}, 32'd10);
        check("drain1 data", wb_data, 32'hA10);
        #1 check("one ready", {31'd0, lr_ready}, 32'd1);
        tick();
        lr_valid = 0;
        check("drain2 addr", {27'd0, wb_wraddress}, 32'd11);
        check("drain2 data", wb_data, 32'hA11);
        tick();
        check("drain3 addr", {27'd0, wb_wraddress}, 32'd12);
        check("drain3 data", wb_data, 32'hA12);
        tick();
        check("drained wren", {31'd0, wb_wren}, 32'd0);

        // Same-cycle clear and re-issue of r7: set wins
`ifdef RF_WB_BYPASS_EN
        lr_valid = 1; lr_addr = 7; lr_data = 32'h77;
        iss_valid = 1; iss_addr = 7;
        #1 check("iss7 ready", {31'd0, iss_ready}, 32'd1);
        tick();
        lr_valid = 0; iss_valid = 0;
`else
        lr_valid = 1; lr_addr = 7; lr_data = 32'h77;
        tick();
        lr_valid = 0;
        iss_valid = 1; iss_addr = 7;
        #1 check("iss7 ready", {31'd0, iss_ready}, 32'd1);
        tick();
        iss_valid = 0;
`endif
        check("r7 written", {27'd0, wb_wraddress}, 32'd7);
        chk_addr_b = 7;
        #1 check("r7 still pending", {31'd0, hazard_b}, 32'd1);
        iss_valid = 1; iss_addr = 7;
        #1 check("r7 reissue rejected", {31'd0, iss_ready}, 32'd0);
        iss_valid = 0;
        lr_valid = 1; lr_addr = 7; lr_data = 32'h78;
        tick();
        lr_valid = 0;
        tick();
        #1 check("r7 cleared", {31'd0, hazard_b}, 32'd0);
        tick();

        // Pause with one buffered entry
        iss_valid = 1; iss_addr = 13;
        tick();
        iss_valid = 0;
        alu_wren = 1; alu_wraddr = 4; alu_data = 32'h444;
        lr_valid = 1; lr_addr = 13; lr_data = 32'hD13;
        tick();
        alu_wren = 0; pause = 1;
        iss_valid = 1; iss_addr = 20;
        lr_addr = 21; lr_data = 32'hD21;
        chk_addr_a = 13; chk_addr_b = 20;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("pause lr_ready", {31'd0, lr_ready}, 32'd0);
            check("pause iss_ready", {31'd0, iss_ready}, 32'd0);
            check("pause hazard13", {31'd0, hazard_a}, 32'd1);
            tick();
            check("pause wren", {31'd0, wb_wren}, 32'd1);
            check("pause addr", {27'd0, wb_wraddress}, 32'd4);
            check("pause data", wb_data, 32'h444);
        end
        pause = 0; iss_valid = 0; lr_valid = 0;
        tick();
        check("post-pause addr", {27'd0, wb_wraddress}, 32'd13);
        check("post-pause data", wb_data, 32'hD13);
        #1;
        check("r13 cleared", {31'd0, hazard_a}, 32'd0);
        check("r20 not issued", {31'd0, hazard_b}, 32'd0);

        // Long result to r0 is accepted and discarded
        lr_valid = 1; lr_addr = 0; lr_data = 32'hFFFF;
        #1 check("r0 lr_ready", {31'd0, lr_ready}, 32'd1);
        tick();
        lr_valid = 0;
        check("r0 wren a", {31'd0, wb_wren}, 32'd0);
        tick();
        check("r0 wren b", {31'd0, wb_wren}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wb_arb.md
# rf_wb_arb

Write-back arbiter that drives the single write port of the register array. It merges the every-cycle ALU write-back with results from the long-latency units (load, mul/div) arriving on a valid/ready handshake. Late results sit in a 2-entry buffer until the ALU leaves a write slot free. It also keeps a pending-write scoreboard, so decode stalls on reads of registers still owed a long-latency result.

## Interface
Parameters:
- none; depth and encodings come from shared defines.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- pause  in  1  pipeline freeze; same signal the register array sees.
- alu_wren  in  1  ALU write request this cycle.
- alu_wraddr  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- lr_valid  in  1  long-latency result offered.
- lr_ready  out  1  result accepted this cycle when lr_valid and lr_ready are both 1.
- lr_addr  in  5  long-latency destination.
- lr_data  in  32  long-latency result.
- iss_valid  in  1  decode issues a long-latency op.
- iss_addr  in  5  its destination.
- iss_ready  out  1  issue accepted.
- chk_addr_a, chk_addr_b  in  5 each  source registers being decoded.
- hazard_a, hazard_b  out  1 each  source is pending.
- wb_data  out  32  to register array data.
- wb_wraddress  out  5  to register array wraddress.
- wb_wren  out  1  to register array wren.

## Operation
- Write slot is free when alu_wren=0 or alu_wraddr=0.
- ALU writes always win and are never delayed.
- Register 0 is never written: wb_wren=0 for any winner addressed to r0.
- A long result addressed to r0 is accepted and discarded.
- Buffer FSM states: EMPTY, ONE, FULL.
  - lr_ready = !pause && state!=FULL.
  - Accept pushes the result; a free slot pops the head (FIFO order).
  - Push and pop in the same cycle leave the state unchanged.
  - With the buffer in EMPTY, a free slot and an accept, the result bypasses the buffer (see Configuration).
- Scoreboard pending[31:1], reset all 0.
  - Issue accept (iss_valid && iss_ready) sets pending[iss_addr]. iss_addr=0 is accepted with no effect.
  - Writing a long result clears pending[addr].
  - Same-cycle set and clear on one address: set wins.
  - iss_ready = !pause && !pending[iss_addr], so each register has at most one outstanding result.
- hazard_x = pending[chk_addr_x] (combinational). Always 0 for address 0.
- An ALU write to a pending register is legal; the later long result overwrites it.
- pause=1 freezes all state and registered outputs. lr_ready=0 and iss_ready=0 while paused.

## Timing
- wb_* are registered and are 0 after reset.
- ALU path latency: 1 cycle (inputs at edge N appear on wb_* after edge N).
- Long result, bypass: 1 cycle after accept. Buffered: 1 cycle after the first free slot following accept.
- Scoreboard:
  - A set takes effect the cycle after issue.
  - A clear takes effect in the same cycle wb_wren carries the result, which matches the register array's own write-through timing.
- Reset mid-operation flushes the buffer, clears the scoreboard and zeroes outputs. The long-latency units must be reset in the same cycle.

## Configuration
- RF_WB_BYPASS_EN defined: EMPTY + free slot + accept writes the result directly, with 1-cycle latency and no buffer entry.
- RF_WB_BYPASS_EN undefined: every long result passes through the buffer. Minimum latency is 2 cycles; lr_ready is unchanged.

## Structure
- Shared defines go in the common mips789 defines file:
  - WB_ST_EMPTY / WB_ST_ONE / WB_ST_FULL encodings (2 bits).
  - WB_FIFO_DEPTH = 2.
- One sub-module, wb_fifo2: the 2-entry 37-bit (addr+data) buffer holding the FSM, with push, pop, head, full and empty.
- Scoreboard and arbitration live in the top.

## Test plan
- Reset, then idle: wb_wren=0, wb_data=0, lr_ready=1, hazard_a=0 for all addresses.
- alu_wren=1, addr 5, data 0x1234 with lr_valid=0: next cycle wb_wren=1, wb_wraddress=5, wb_data=0x1234.
- Issue addr 9, then lr_valid for addr 9, data 0xDEADBEEF, with the ALU idle:
  - hazard for chk 9 reads 1 until the write.
  - With bypass on, written 1 cycle after accept; with bypass off, 2 cycles after accept.
  - pending[9] then reads 0.
- ALU writes every cycle to nonzero registers while 3 long results arrive:
  - lr_ready drops after 2 accepts.
  - When the ALU frees slots, results are written in arrival order.
- Same-cycle clear and re-issue of addr 7: pending[7] stays 1. iss_addr 7 is then rejected (iss_ready=0).
- pause=1 for 3 cycles with the buffer holding 1 entry: wb_*, state and scoreboard are unchanged, and lr_ready and iss_ready are 0. A long result to r0 is accepted and produces wb_wren=0.
